gri_peak_window_sched: RTL and testbench
========================================

Name: gri_peak_window_sched

Overview:
- Sequences the correlation-peak search for one GRI pulse group.
- Acquires the first pulse peak as the anchor, then opens a gated search window around each following pulse position (anchor + k*spacing).
- Forwards only in-window peaks to the phase decoder, flags missing pulses, and reports group completion or abort.
- Sits between the correlator peak detector and the phase-decoding block.

Parameters:
- PULSE_SPACING, 1000: nominal sample distance between pulses 0..7.
- MASTER_OFFSET, 9000: offset of pulse 8 (master only) from the anchor.
- WIN_HALF, 16: half-width of each search window in samples; window is inclusive on both ends.
- ACQ_LEN, 2000: maximum number of samples to wait for the anchor peak.

Ports:
- sys_clk  in  1  system clock
- sys_rstn  in  1  reset, asynchronous, active-low
- gri_valid  in  1  GRI data-valid level; rising edge starts a group
- gri_mxy  in  1  latched at group start; 0 = master (9 pulses), 1 = secondary (8 pulses)
- sample_en  in  1  one-cycle strobe per input sample
- peak_valid  in  1  correlator peak strobe
- peak_index  in  16  sample index of peak, relative to group start
- win_en  out  1  search window open
- win_idx  out  4  pulse index of current or last window (0..8)
- peak_out_valid  out  1  accepted-peak strobe to decoder
- peak_out_index  out  16  accepted peak index
- pulse_miss  out  1  one-cycle strobe: window closed with no peak
- miss_cnt  out  4  missing pulses in current group
- group_done  out  1  one-cycle strobe: group finished
- group_abort  out  1  one-cycle strobe: group abandoned

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal counters 0.
- Start detection: gri_valid is registered; start = registered level high AND previous value low (rising edge).
- samp_cnt (16-bit):
  - Cleared on start.
  - Incremented on sample_en in every state except IDLE.
  - Reaching 0xFFFF in any non-IDLE state forces ABORT.
- Group latch on start: gri_mxy is latched; last_idx = 8 if gri_mxy = 0, else 7.
- Offset table: off(k) = k*PULSE_SPACING for k = 1..7; off(8) = MASTER_OFFSET.
- Window bounds for pulse k: open at anchor + off(k) - WIN_HALF, close at anchor + off(k) + WIN_HALF. Computed in 17 bits; a carry out (window beyond 0xFFFF) forces ABORT.
- IDLE:
  - Wait for start, then go to ACQ.
  - In ACQ: win_en = 1, win_idx = 0.
- ACQ:
  - First peak_valid: anchor <= peak_index; forward the peak; k <= 1; go to GAP.
  - samp_cnt reaches ACQ_LEN with no peak: go to ABORT (no anchor means no group).
- GAP:
  - win_en = 0.
  - When samp_cnt equals the open bound of pulse k: go to WIN; win_en = 1; win_idx = k.
- WIN:
  - First peak_valid: forward it; set the window's got flag. Later peaks in the same window are dropped.
  - When samp_cnt equals the close bound and a sample_en occurs, the window closes:
    - got flag clear: pulse_miss = 1 and miss_cnt += 1 (saturates at 15).
    - k == last_idx: go to DONE.
    - otherwise: k += 1; go to GAP.
  - A peak_valid on the closing cycle counts as in-window and is accepted; no miss is flagged.
- DONE: group_done = 1 for one cycle, then IDLE. miss_cnt holds until the next start.
- ABORT: group_abort = 1 for one cycle, then IDLE. Any window in progress closes with no pulse_miss.
- Peak forwarding:
  - peak_out_valid is asserted exactly 1 cycle after the accepted peak_valid.
  - peak_out_index = the registered peak_index.
- peak_valid in IDLE or GAP: ignored, no output.
- start while in ACQ/GAP/WIN:
  - group_abort pulses in the same cycle as the restart.
  - Counters are cleared and the FSM enters ACQ on the next cycle.
  - Any peak_valid in that same cycle is dropped.
- Reset asserted mid-group: immediate return to reset values; no done or abort strobe is issued.

Test Plan:
1. Master group, gri_mxy = 0, peaks at 40, 1040, …, 7040, 9040 → 9 peak_out_valid strobes, each 1 cycle late; win_idx steps 0..8; group_done once; miss_cnt = 0.
2. Secondary group, gri_mxy = 1, peaks at 100 + k*1000 for k = 0..7 → 8 forwards; group_done after the pulse-7 window closes; no pulse-8 window opens.
3. Anchor 40; pulse 3 peak withheld; an extra peak at 2500 in GAP → pulse_miss when samp_cnt passes 3056; miss_cnt = 1; peak at 2500 not forwarded.
4. Anchor 40; pulse-1 peaks at 1024 and 1056 (both window edges), then a second peak at 1050 → 1024 accepted; 1050 dropped. Separate run with the sole peak at 1056 on the closing cycle → accepted, no miss.
5. No peak within 2000 samples of start → group_abort at samp_cnt 2000; no peak_out_valid; FSM returns to IDLE.
6. New gri_valid rising edge while in the pulse-4 window → group_abort strobe; samp_cnt = 0; FSM in ACQ. Separately, sys_rstn low mid-WIN → all outputs 0 immediately.

Source files
------------

// File: rtl/gri_peak_window_sched.sv
// GRI pulse-group peak scheduler: acquires an anchor peak, then gates one search
// window per following pulse and forwards only in-window peaks to the phase decoder.
module gri_peak_window_sched #(
  parameter int unsigned PULSE_SPACING = 1000,
  parameter int unsigned MASTER_OFFSET = 9000,
  parameter int unsigned WIN_HALF      = 16,
  parameter int unsigned ACQ_LEN       = 2000
) (
  input  logic        sys_clk,
  input  logic        sys_rstn,
  input  logic        gri_valid,
  input  logic        gri_mxy,
  input  logic        sample_en,
  input  logic        peak_valid,
  input  logic [15:0] peak_index,
  output logic        win_en,
  output logic [3:0]  win_idx,
  output logic        peak_out_valid,
  output logic [15:0] peak_out_index,
  output logic        pulse_miss,
  output logic [3:0]  miss_cnt,
  output logic        group_done,
  output logic        group_abort,
  output logic [2:0]  dbg_state
);

  // Handshake: every strobe here is a single-cycle pulse with no back-pressure;
  // sample_en and peak_valid are sampled on the same edge, peak_out_valid
  // follows an accepted peak_valid by exactly one cycle.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACQ   = 3'd1,
    S_GAP   = 3'd2,
    S_WIN   = 3'd3,
    S_DONE  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam logic [16:0] L_SPACING = 17'(PULSE_SPACING);
  localparam logic [16:0] L_MASTER  = 17'(MASTER_OFFSET);
  localparam logic [16:0] L_HALF    = 17'(WIN_HALF);
  localparam logic [15:0] L_ACQ_LEN = 16'(ACQ_LEN);

  state_t      r_state;
  state_t      w_next;
  logic        r_gri_q;
  logic        r_gri_q2;
  logic [15:0] r_samp_cnt;
  logic [15:0] r_anchor;
  logic [15:0] r_poi;
  logic [3:0]  r_k;
  logic [3:0]  r_win_idx;
  logic [3:0]  r_miss_cnt;
  logic        r_mxy;
  logic        r_got;
  logic        r_pov;

  logic        w_start;
  logic        w_active;
  logic [3:0]  w_last_idx;
  logic [16:0] w_off;
  logic [16:0] w_open;
  logic [16:0] w_close;
  logic        w_force_abort;
  logic        w_open_hit;
  logic        w_close_evt;
  logic        w_accept;
  logic        w_miss;

  assign w_start    = r_gri_q & ~r_gri_q2;
  assign w_active   = r_state inside {S_ACQ, S_GAP, S_WIN};
  assign w_last_idx = r_mxy ? 4'd7 : 4'd8;

  // Bounds kept at 17 bits so a window past the 16-bit sample range shows as bit 16.
  assign w_off   = (r_k == 4'd8) ? L_MASTER : ({13'd0, r_k} * L_SPACING);
  assign w_open  = {1'b0, r_anchor} + w_off - L_HALF;
  assign w_close = {1'b0, r_anchor} + w_off + L_HALF;

  assign w_force_abort = w_active && !w_start &&
                         ((r_samp_cnt == 16'hFFFF) ||
                          (((r_state == S_GAP) || (r_state == S_WIN)) && w_close[16]));
  assign w_open_hit    = (r_state == S_GAP) && !w_start && !w_force_abort &&
                         (w_open == {1'b0, r_samp_cnt});
  assign w_close_evt   = (r_state == S_WIN) && !w_start && !w_force_abort && sample_en &&
                         (w_close == {1'b0, r_samp_cnt});
  // The opening cycle in GAP already counts as inside the window.
  assign w_accept      = peak_valid && !w_start && !w_force_abort &&
                         ((r_state == S_ACQ) || w_open_hit || ((r_state == S_WIN) && !r_got));
  assign w_miss        = w_close_evt && !r_got && !w_accept;

  always_comb begin
    w_next      = r_state;
    win_en      = 1'b0;
    win_idx     = r_win_idx;
    pulse_miss  = 1'b0;
    group_done  = 1'b0;
    group_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_ACQ;
      end
      S_ACQ: begin
        win_en = 1'b1;
        if (w_start)                       w_next = S_ACQ;
        else if (w_force_abort)            w_next = S_ABORT;
        else if (peak_valid)               w_next = S_GAP;
        else if (r_samp_cnt == L_ACQ_LEN)  w_next = S_ABORT;
      end
      S_GAP: begin
        if (w_open_hit) begin
          win_en  = 1'b1;
          win_idx = r_k;
        end
        if (w_start)            w_next = S_ACQ;
        else if (w_force_abort) w_next = S_ABORT;
        else if (w_open_hit)    w_next = S_WIN;
      end
      S_WIN: begin
        win_en     = 1'b1;
        pulse_miss = w_miss;
        if (w_start)            w_next = S_ACQ;
        else if (w_force_abort) w_next = S_ABORT;
        else if (w_close_evt)   w_next = (r_k == w_last_idx) ? S_DONE : S_GAP;
      end
      S_DONE: begin
        group_done = 1'b1;
        w_next     = w_start ? S_ACQ : S_IDLE;
      end
      S_ABORT: begin
        group_abort = 1'b1;
        w_next      = w_start ? S_ACQ : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_active && w_start) group_abort = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state    <= S_IDLE;
      r_gri_q    <= 1'b0;
      r_gri_q2   <= 1'b0;
      r_samp_cnt <= 16'd0;
      r_anchor   <= 16'd0;
      r_k        <= 4'd0;
      r_win_idx  <= 4'd0;
      r_miss_cnt <= 4'd0;
      r_mxy      <= 1'b0;
      r_got      <= 1'b0;
      r_pov      <= 1'b0;
      r_poi      <= 16'd0;
    end else begin
      r_state  <= w_next;
      r_gri_q  <= gri_valid;
      r_gri_q2 <= r_gri_q;
      r_pov    <= w_accept;
      if (w_accept) r_poi <= peak_index;

      if (w_start)                                 r_samp_cnt <= 16'd0;
      else if ((r_state != S_IDLE) && sample_en)   r_samp_cnt <= r_samp_cnt + 16'd1;

      if (w_start) begin
        r_mxy      <= gri_mxy;
        r_anchor   <= 16'd0;
        r_k        <= 4'd0;
        r_win_idx  <= 4'd0;
        r_miss_cnt <= 4'd0;
        r_got      <= 1'b0;
      end else begin
        if ((r_state == S_ACQ) && w_accept) begin
          r_anchor <= peak_index;
          r_k      <= 4'd1;
        end
        if (w_open_hit) begin
          r_win_idx <= r_k;
          r_got     <= w_accept;
        end else if ((r_state == S_WIN) && w_accept) begin
          r_got <= 1'b1;
        end
        if (w_close_evt) begin
          r_got <= 1'b0;
          if (r_k != w_last_idx) r_k <= r_k + 4'd1;
        end
        if (w_miss && (r_miss_cnt != 4'd15)) r_miss_cnt <= r_miss_cnt + 4'd1;
      end
    end
  end

  assign peak_out_valid = r_pov;
  assign peak_out_index = r_poi;
  assign miss_cnt       = r_miss_cnt;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_gri_peak_window_sched.sv
// Bench for gri_peak_window_sched: randomized sample strobes and peak plans,
// checked against a window-rule model evaluated over each group's emitted peaks.
module tb_gri_peak_window_sched;

  localparam int SP  = 1000;
  localparam int MO  = 9000;
  localparam int WH  = 16;
  localparam int AL  = 2000;
  localparam int BIG = 1 << 30;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        gri_valid = 1'b0;
  logic        gri_mxy = 1'b0;
  logic        sample_en = 1'b0;
  logic        peak_valid = 1'b0;
  logic [15:0] peak_index = 16'd0;
  logic        win_en;
  logic [3:0]  win_idx;
  logic        peak_out_valid;
  logic [15:0] peak_out_index;
  logic        pulse_miss;
  logic [3:0]  miss_cnt;
  logic        group_done;
  logic        group_abort;
  logic [2:0]  dbg_state;

  gri_peak_window_sched dut (
    .sys_clk        (clk),
    .sys_rstn       (rstn),
    .gri_valid      (gri_valid),
    .gri_mxy        (gri_mxy),
    .sample_en      (sample_en),
    .peak_valid     (peak_valid),
    .peak_index     (peak_index),
    .win_en         (win_en),
    .win_idx        (win_idx),
    .peak_out_valid (peak_out_valid),
    .peak_out_index (peak_out_index),
    .pulse_miss     (pulse_miss),
    .miss_cnt       (miss_cnt),
    .group_done     (group_done),
    .group_abort    (group_abort),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // group bookkeeping
  int          plan_q[$];
  int          em_cnt_q[$];
  int          em_cyc_q[$];
  logic [15:0] obs_idx_q[$];
  int          obs_win_q[$];
  int          obs_cyc_q[$];
  int          obs_miss_q[$];
  int          count;
  int          prev_count;
  int          n_done;
  int          n_abort;
  int          abort_prev_cnt;
  int          max_win;
  bit          grp_mxy;

  task automatic clear_grp();
    plan_q.delete(); em_cnt_q.delete(); em_cyc_q.delete();
    obs_idx_q.delete(); obs_win_q.delete(); obs_cyc_q.delete(); obs_miss_q.delete();
    count = 0; prev_count = 0; n_done = 0; n_abort = 0; abort_prev_cnt = -1; max_win = 0;
  endtask

  task automatic monitor();
    if (peak_out_valid) begin
      obs_idx_q.push_back(peak_out_index);
      obs_win_q.push_back(32'(win_idx));
      obs_cyc_q.push_back(cyc);
    end
    if (pulse_miss) obs_miss_q.push_back(count);
    if (win_en && (32'(win_idx) > max_win)) max_win = 32'(win_idx);
    if (group_done) n_done++;
    if (group_abort) begin
      n_abort++;
      abort_prev_cnt = prev_count;
    end
  endtask

  function automatic int pulse_off(input int k);
    return (k == 8) ? MO : k * SP;
  endfunction

  task automatic plan_std(input int a, input bit mxy, input int skip_k);
    int last;
    last = mxy ? 7 : 8;
    for (int k = 0; k <= last; k++)
      if (k != skip_k) plan_q.push_back(a + ((k == 0) ? 0 : pulse_off(k)));
  endtask

  task automatic plan_finalize();
    int tmp[$];
    plan_q.sort();
    foreach (plan_q[i])
      if (tmp.size() == 0 || tmp[tmp.size()-1] != plan_q[i]) tmp.push_back(plan_q[i]);
    plan_q = tmp;
  endtask

  // driver tasks
  task automatic start_group(input bit mxy);
    clear_grp();
    grp_mxy = mxy;
    gri_mxy = mxy;
    @(negedge clk); gri_valid = 1'b1; sample_en = 1'b0; peak_valid = 1'b0; #1;
    @(negedge clk); sample_en = 1'b0; peak_valid = 1'b0; #1;
    check("start_no_abort", 32'(group_abort), 0);
    @(posedge clk); #1;
    check("acq_state", 32'(dbg_state), 1);
    check("acq_win_en", 32'(win_en), 1);
    check("acq_win_idx", 32'(win_idx), 0);
    check("acq_miss_cnt", 32'(miss_cnt), 0);
  endtask

  task automatic run_group(input int stop_cnt, output int reason);
    bit pv;
    bit se;
    int budget;
    reason = 3;
    budget = 0;
    while (budget < 14000) begin
      if (count == stop_cnt) begin
        reason = 2;
        break;
      end
      while (plan_q.size() > 0 && plan_q[0] < count) void'(plan_q.pop_front());
      pv = 1'b0;
      se = ($urandom_range(31, 0) != 0);
      if (plan_q.size() > 0 && plan_q[0] == count) begin
        pv = 1'b1;
        se = 1'b1;
        void'(plan_q.pop_front());
      end
      @(negedge clk);
      sample_en  = se;
      peak_valid = pv;
      peak_index = pv ? 16'(count) : 16'($urandom);
      #1;
      if (pv) begin
        em_cnt_q.push_back(count);
        em_cyc_q.push_back(cyc);
      end
      monitor();
      prev_count = count;
      count += 32'(se);
      budget++;
      if (group_done)  begin reason = 0; break; end
      if (group_abort) begin reason = 1; break; end
    end
    if (reason == 3) $display("FAIL group_timeout: got %0d cycles expected a done/abort/stop event", budget);
  endtask

  task automatic finish_group();
    gri_valid = 1'b0;
    repeat (3) begin
      @(negedge clk); sample_en = 1'b0; peak_valid = 1'b0; #1;
    end
    check("back_to_idle", 32'(dbg_state), 0);
  endtask

  // scoreboard: expected forwards/misses derived from the window rules
  task automatic evaluate(input int cut, input int exp_done, input int exp_abort);
    logic [15:0] exp_q[$];
    int exp_win_q[$];
    int exp_cyc_q[$];
    int exp_miss_q[$];
    int a, last, lo, hi, nmiss, kmax;
    bit found;
    bit anchored;
    last = grp_mxy ? 7 : 8;
    nmiss = 0;
    kmax = 0;
    anchored = (em_cnt_q.size() > 0) && (em_cnt_q[0] <= AL);
    if (anchored) begin
      a = em_cnt_q[0];
      exp_q.push_back(16'(a)); exp_win_q.push_back(0); exp_cyc_q.push_back(em_cyc_q[0] + 1);
      for (int k = 1; k <= last; k++) begin
        lo = a + pulse_off(k) - WH;
        hi = a + pulse_off(k) + WH;
        if (lo < cut) begin
          kmax = k;
          found = 1'b0;
          for (int j = 1; j < em_cnt_q.size(); j++)
            if (!found && em_cnt_q[j] >= lo && em_cnt_q[j] <= hi) begin
              found = 1'b1;
              exp_q.push_back(16'(em_cnt_q[j]));
              exp_win_q.push_back(k);
              exp_cyc_q.push_back(em_cyc_q[j] + 1);
            end
          if (!found && hi < cut) begin
            exp_miss_q.push_back(hi);
            nmiss++;
          end
        end
      end
      check("max_win_idx", max_win, kmax);
    end else begin
      check("abort_at_samp", abort_prev_cnt, AL);
    end
    check("n_forwarded", obs_idx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_idx_q.size(); i++) begin
      check("fwd_index", 32'(obs_idx_q[i]), 32'(exp_q[i]));
      check("fwd_win_idx", obs_win_q[i], exp_win_q[i]);
      check("fwd_latency", obs_cyc_q[i], exp_cyc_q[i]);
    end
    check("n_miss", obs_miss_q.size(), exp_miss_q.size());
    for (int i = 0; i < exp_miss_q.size() && i < obs_miss_q.size(); i++)
      check("miss_at_samp", obs_miss_q[i], exp_miss_q[i]);
    check("n_done", n_done, exp_done);
    check("n_abort", n_abort, exp_abort);
    if (exp_done != 0) check("miss_cnt", 32'(miss_cnt), (nmiss > 15) ? 15 : nmiss);
  endtask

  task automatic restart_seq();
    check("pre_restart_win_en", 32'(win_en), 1);
    check("pre_restart_win_idx", 32'(win_idx), 4);
    @(negedge clk); gri_valid = 1'b0; sample_en = 1'b1; peak_valid = 1'b0; #1;
    monitor(); prev_count = count; count++;
    @(negedge clk); gri_valid = 1'b1; sample_en = 1'b1; #1;
    monitor(); prev_count = count; count++;
    @(negedge clk); sample_en = 1'b1; peak_valid = 1'b1; peak_index = 16'(count); #1;
    check("restart_abort", 32'(group_abort), 1);
    evaluate(count, 0, 0);
    clear_grp();
    @(posedge clk); #1;
    check("restart_acq", 32'(dbg_state), 1);
    check("restart_peak_drop", 32'(peak_out_valid), 0);
    check("restart_miss_cnt", 32'(miss_cnt), 0);
    check("restart_win_idx", 32'(win_idx), 0);
  endtask

  task automatic plan_random(input bit mxy);
    int a, last, j;
    a = int'($urandom_range(1900, 0));
    last = mxy ? 7 : 8;
    plan_q.push_back(a);
    for (int k = 1; k <= last; k++) begin
      j = int'($urandom_range(40, 0)) - 20;
      if ($urandom_range(7, 0) != 0) plan_q.push_back(a + pulse_off(k) + j);
    end
    repeat (6) plan_q.push_back(a + int'($urandom_range(9100, 100)));
    plan_finalize();
  endtask

  initial begin
    int reason;
    bit mxy;
    logic [3:0] strobes;

    #1;
    check("reset_outputs", {win_en, win_idx, peak_out_valid, peak_out_index, pulse_miss,
                            miss_cnt, group_done, group_abort, dbg_state}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // master group, all pulses at nominal position
    start_group(1'b0); plan_std(40, 1'b0, -1); plan_finalize();
    run_group(-1, reason); check("t1_reason", reason, 0);
    evaluate(BIG, 1, 0); finish_group();

    // secondary group, no pulse-8 window
    start_group(1'b1); plan_std(100, 1'b1, -1); plan_finalize();
    run_group(-1, reason); check("t2_reason", reason, 0);
    evaluate(BIG, 1, 0); finish_group();

    // pulse 3 withheld, stray peak in the gap
    start_group(1'b1); plan_std(40, 1'b1, 3); plan_q.push_back(2500); plan_finalize();
    run_group(-1, reason); check("t3_reason", reason, 0);
    evaluate(BIG, 1, 0); finish_group();

    // both window edges plus a second in-window peak
    start_group(1'b1); plan_std(40, 1'b1, 1);
    plan_q.push_back(1024); plan_q.push_back(1050); plan_q.push_back(1056); plan_finalize();
    run_group(-1, reason); check("t4a_reason", reason, 0);
    evaluate(BIG, 1, 0); finish_group();

    // sole peak on the closing cycle
    start_group(1'b1); plan_std(40, 1'b1, 1); plan_q.push_back(1056); plan_finalize();
    run_group(-1, reason); check("t4b_reason", reason, 0);
    evaluate(BIG, 1, 0); finish_group();

    // no anchor within the acquisition limit
    start_group(1'b0);
    run_group(-1, reason); check("t5_reason", reason, 1);
    evaluate(BIG, 0, 1); finish_group();

    // restart inside the pulse-4 window, then a full group
    start_group(1'b1); plan_std(40, 1'b1, -1); plan_finalize();
    run_group(4030, reason); check("t6_reason", reason, 2);
    restart_seq();
    plan_std(500, 1'b1, -1); plan_finalize();
    run_group(-1, reason); check("t6b_reason", reason, 0);
    evaluate(BIG, 1, 0); finish_group();

    // randomized groups
    repeat (2) begin
      mxy = 1'($urandom_range(1, 0));
      start_group(mxy); plan_random(mxy);
      run_group(-1, reason); check("rand_reason", reason, 0);
      evaluate(BIG, 1, 0); finish_group();
    end

    // reset asserted mid-window
    start_group(1'b1); plan_std(300, 1'b1, -1); plan_finalize();
    run_group(2287, reason); check("t7_reason", reason, 2);
    check("pre_reset_win_en", 32'(win_en), 1);
    evaluate(count, 0, 0);
    #2 rstn = 1'b0;
    #1;
    check("reset_mid_win", {win_en, win_idx, peak_out_valid, peak_out_index, pulse_miss,
                            miss_cnt, group_done, group_abort, dbg_state}, 0);
    gri_valid = 1'b0; sample_en = 1'b0; peak_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    strobes = 4'd0;
    repeat (5) begin
      @(negedge clk); #1;
      strobes = strobes | {group_done, group_abort, pulse_miss, peak_out_valid};
    end
    check("post_reset_strobes", 32'(strobes), 0);
    check("post_reset_idle", 32'(dbg_state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
